// File: rtl/rc4_pkg.sv
// rc4_pkg: shared definitions for the RC4 key schedule and decrypt stages.
//   ksa_state_t  - key-schedule FSM states
//   SBOX_DEPTH   - number of S-box entries
//   RAM_RD_WAIT  - wait states between driving the RAM address and using q
//   key_byte_at  - extracts key byte n (byte 0 = most significant byte)
package rc4_pkg;

    localparam int unsigned SBOX_DEPTH  = 256;
    localparam int unsigned RAM_RD_WAIT = 1;
    // Widest secret key key_byte_at accepts; narrower keys are zero-extended.
    localparam int unsigned KEY_W_MAX   = 256;

    typedef enum logic [3:0] {
        KSA_IDLE,
        KSA_FILL,
        KSA_RD_I,
        KSA_WAIT_I,
        KSA_CALC_J,
        KSA_RD_J,
        KSA_WAIT_J,
        KSA_LATCH_J,
        KSA_WR_I,
        KSA_WR_J,
        KSA_NEXT,
        KSA_DONE
    } ksa_state_t;

    // Byte n of a key_bytes-long key held right-aligned in key.
    function automatic logic [7:0] key_byte_at(input logic [KEY_W_MAX-1:0] key,
                                               input int unsigned         n,
                                               input int unsigned         key_bytes);
        logic [KEY_W_MAX-1:0] sh;
        sh = key >> (8 * (key_bytes - 1 - n));
        return sh[7:0];
    endfunction

endpackage

// File: rtl/rc4_key_byte_sel.sv
// rc4_key_byte_sel: wrapping key-index counter (i mod KEY_BYTES) and key byte mux.
//   clk, reset  - clock, synchronous active-high reset
//   clear       - restart the index at 0
//   advance     - step the index, wrapping after KEY_BYTES-1
//   key         - registered secret key, byte 0 in the top byte
//   key_byte    - key byte selected by the current index
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned KEY_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [KEY_W-1:0] key,
    output logic [7:0]       key_byte
);

    localparam int unsigned IDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(KEY_BYTES - 1);

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [KEY_W_MAX-1:0] key_ext;

    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (advance) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    always_comb begin
        key_ext            = '0;
        key_ext[KEY_W-1:0] = key;
        key_byte           = key_byte_at(key_ext, 32'(idx_q), KEY_BYTES);
    end

endmodule

// File: rtl/rc4_key_schedule.sv
// rc4_key_schedule: RC4 key-scheduling algorithm on an external 256x8 S-box RAM.
// Fills S[i]=i, then performs 256 key-driven swaps; done stays high afterwards
// and enables the downstream decrypt stage.
//   clk, reset   - clock, synchronous active-high reset
//   start        - begin a run (accepted only in IDLE or DONE)
//   secret_key   - key, byte 0 = secret_key[KEY_W-1:KEY_W-8]
//   address/data/wren - registered S-box RAM port
//   q            - RAM read data, valid two cycles after address is driven
//   busy, done   - run status
//   cycle_count  - busy-cycle counter, present only with KSA_CYCLE_COUNT_EN
module rc4_key_schedule
    import rc4_pkg::*;
#(
    parameter int unsigned KEY_BYTES = 3,
    parameter int unsigned KEY_W     = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    output logic [7:0]       address,
    output logic [7:0]       data,
    output logic             wren,
    input  logic [7:0]       q,
    output logic             busy,
    output logic             done
`ifdef KSA_CYCLE_COUNT_EN
    ,
    output logic [15:0]      cycle_count
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(SBOX_DEPTH - 1);

    ksa_state_t       state_q, state_d;
    logic [7:0]       i_q, i_d;
    logic [7:0]       j_q, j_d;
    logic [7:0]       si_q, si_d;
    logic [7:0]       sj_q, sj_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [7:0]       address_q, address_d;
    logic [7:0]       data_q, data_d;
    logic             wren_q, wren_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             key_advance;
    logic [7:0]       key_byte;

    rc4_key_byte_sel #(
        .KEY_BYTES(KEY_BYTES),
        .KEY_W    (KEY_W)
    ) u_key_byte_sel (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (key_advance),
        .key     (key_q),
        .key_byte(key_byte)
    );

    // State register plus all registered datapath/outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= KSA_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            key_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            key_q     <= key_d;
            address_q <= address_d;
            data_q    <= data_d;
            wren_q    <= wren_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KSA_IDLE, KSA_DONE: if (start) state_d = KSA_FILL;
            KSA_FILL:           if (i_q == LAST_IDX) state_d = KSA_RD_I;
            KSA_RD_I:           state_d = KSA_WAIT_I;
            KSA_WAIT_I:         state_d = KSA_CALC_J;
            KSA_CALC_J:         state_d = KSA_RD_J;
            KSA_RD_J:           state_d = KSA_WAIT_J;
            KSA_WAIT_J:         state_d = KSA_LATCH_J;
            KSA_LATCH_J:        state_d = KSA_WR_I;
            KSA_WR_I:           state_d = KSA_WR_J;
            KSA_WR_J:           state_d = KSA_NEXT;
            KSA_NEXT:           state_d = (i_q == LAST_IDX) ? KSA_DONE : KSA_RD_I;
            default:            state_d = KSA_IDLE;
        endcase
    end

    // Output and datapath logic. wren defaults low so it can only rise in
    // FILL, WR_I and WR_J.
    always_comb begin
        i_d         = i_q;
        j_d         = j_q;
        si_d        = si_q;
        sj_d        = sj_q;
        key_d       = key_q;
        address_d   = address_q;
        data_d      = data_q;
        wren_d      = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;
        accept      = 1'b0;
        key_advance = 1'b0;
        unique case (state_q)
            KSA_IDLE, KSA_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    key_d  = secret_key;
                    i_d    = '0;
                    j_d    = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            KSA_FILL: begin
                address_d = i_q;
                data_d    = i_q;
                wren_d    = 1'b1;
                i_d       = i_q + 8'd1;   // wraps to 0 after the last entry
            end
            KSA_RD_I:    address_d = i_q;
            KSA_CALC_J: begin
                si_d = q;
                j_d  = j_q + q + key_byte;
            end
            KSA_RD_J:    address_d = j_q;
            KSA_LATCH_J: sj_d = q;
            KSA_WR_I: begin
                address_d = i_q;
                data_d    = sj_q;
                wren_d    = 1'b1;
            end
            // When i==j this rewrites the same address with the original S[i].
            KSA_WR_J: begin
                address_d = j_q;
                data_d    = si_q;
                wren_d    = 1'b1;
            end
            KSA_NEXT: begin
                if (i_q == LAST_IDX) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    i_d         = i_q + 8'd1;
                    key_advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef KSA_CYCLE_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
`endif

endmodule
